// File: rtl/spi_sclk_engine.sv
// SPI master serial-clock engine: SCLK generation for all CPOL/CPHA modes,
// sample/shift strobes and a start/busy/done frame handshake.
module spi_sclk_engine #(
   parameter int SPPR_W = 3,
   parameter int SPR_W  = 3,
   parameter int DIV_W  = 12,
   parameter int LEN_W  = 5
) (
   input  logic              PCLK,
   input  logic              PRESET_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              wait_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic [SPPR_W-1:0] sppr_i,
   input  logic [SPR_W-1:0]  spr_i,
   input  logic [LEN_W-1:0]  frame_len_i,
   output logic              sclk_o,
   output logic              sample_o,
   output logic              shift_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [LEN_W-1:0]  bit_cnt_o,
   output logic [DIV_W-1:0]  divisor_o
);

   typedef enum logic [1:0] {IDLE, RUN, TRAIL} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   hc_q, hc_d;
   logic [DIV_W-1:0]   hm1_q, hm1_d;
   logic [LEN_W:0]     ec_q, ec_d;
   logic [LEN_W:0]     last_q, last_d;
   logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic               ph_q, ph_d;
   logic               own_q, own_d;
   logic               sample_q, sample_d;
   logic               shift_q, shift_d;
   logic               done_q, done_d;

   logic [DIV_W-1:0]   pre;
   logic [DIV_W-1:0]   h_cfg;
   logic [SPR_W:0]     div_sh;
   logic [LEN_W:0]     last_cfg;
   logic               hit;
   logic               lead;
   logic               fin;
   logic               smp_edge;

   always_comb begin
      pre       = DIV_W'(sppr_i) + DIV_W'(1);
      div_sh    = {1'b0, spr_i} + (SPR_W+1)'(1);
      divisor_o = pre << div_sh;
      h_cfg     = pre << spr_i;
      // frame_len 0 wraps to 2^LEN_W bits, so 2N-1 is all ones
      last_cfg  = {frame_len_i, 1'b0} - (LEN_W+1)'(1);
      hit       = (hc_q == hm1_q);
      lead      = ~ec_q[0];
      fin       = (ec_q == last_q);
      smp_edge  = lead ^ cpha_q;
   end

   always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      hm1_d     = hm1_q;
      ec_d      = ec_q;
      last_d    = last_q;
      bit_cnt_d = bit_cnt_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      ph_d      = ph_q;
      own_d     = 1'b0;
      sample_d  = 1'b0;
      shift_d   = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = RUN;
               hc_d      = '0;
               ec_d      = '0;
               bit_cnt_d = '0;
               cpol_d    = cpol_i;
               cpha_d    = cpha_i;
               hm1_d     = h_cfg - DIV_W'(1);
               last_d    = last_cfg;
               ph_d      = 1'b0;
               own_d     = 1'b1;
            end
         end
         RUN: begin
            own_d = 1'b1;
            if (abort_i) begin
               state_d = IDLE;
               ph_d    = 1'b0;
            end else if (!wait_i) begin
               if (hit) begin
                  hc_d = '0;
                  ph_d = ~ph_q;
                  ec_d = ec_q + (LEN_W+1)'(1);
                  if (smp_edge) begin
                     sample_d  = 1'b1;
                     bit_cnt_d = bit_cnt_q + LEN_W'(1);
                  end else if (!fin) begin
                     shift_d = 1'b1;
                  end
                  if (fin) state_d = TRAIL;
               end else begin
                  hc_d = hc_q + DIV_W'(1);
               end
            end
         end
         TRAIL: begin
            own_d = 1'b1;
            if (abort_i) begin
               state_d = IDLE;
               ph_d    = 1'b0;
            end else if (!wait_i) begin
               if (hit) begin
                  state_d = IDLE;
                  hc_d    = '0;
                  done_d  = 1'b1;
                  own_d   = 1'b0;
               end else begin
                  hc_d = hc_q + DIV_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q   <= IDLE;
         hc_q      <= '0;
         hm1_q     <= '0;
         ec_q      <= '0;
         last_q    <= '0;
         bit_cnt_q <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         ph_q      <= 1'b0;
         own_q     <= 1'b0;
         sample_q  <= 1'b0;
         shift_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hc_q      <= hc_d;
         hm1_q     <= hm1_d;
         ec_q      <= ec_d;
         last_q    <= last_d;
         bit_cnt_q <= bit_cnt_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         ph_q      <= ph_d;
         own_q     <= own_d;
         sample_q  <= sample_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
      end
   end

   // own_q holds the latched polarity for the frame and one cycle past an abort
   assign sclk_o    = own_q ? (cpol_q ^ ph_q) : cpol_i;
   assign sample_o  = sample_q;
   assign shift_o   = shift_q;
   assign done_o    = done_q;
   assign busy_o    = (state_q != IDLE);
   assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: modes, divisors, wrap, wait, abort,
// back-to-back frames and mid-frame reset.
module tb_spi_sclk_engine;

   logic        PCLK;
   logic        PRESET_n;
   logic        start_i, abort_i, wait_i, cpol_i, cpha_i;
   logic [2:0]  sppr_i, spr_i;
   logic [4:0]  frame_len_i;
   logic        sclk_o, sample_o, shift_o, busy_o, done_o;
   logic [4:0]  bit_cnt_o;
   logic [11:0] divisor_o;

   int n_cmp = 0;
   int n_bad = 0;

   spi_sclk_engine dut (
      .PCLK(PCLK), .PRESET_n(PRESET_n),
      .start_i(start_i), .abort_i(abort_i), .wait_i(wait_i),
      .cpol_i(cpol_i), .cpha_i(cpha_i),
      .sppr_i(sppr_i), .spr_i(spr_i), .frame_len_i(frame_len_i),
      .sclk_o(sclk_o), .sample_o(sample_o), .shift_o(shift_o),
      .busy_o(busy_o), .done_o(done_o),
      .bit_cnt_o(bit_cnt_o), .divisor_o(divisor_o)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic cfg(input logic pol, input logic pha,
                      input logic [2:0] pp, input logic [2:0] r,
                      input logic [4:0] n);
      cpol_i = pol; cpha_i = pha;
      sppr_i = pp; spr_i = r; frame_len_i = n;
   endtask

   // Runs one frame from the start-sampling edge and collects observations.
   task automatic measure(input int budget, input int wait_at, input int wait_len,
                          output int first_e, output int last_e, output int edges,
                          output int ns, output int nsh, output int done_c,
                          output int ndone, output int bc_done,
                          output bit alt_ok, output bit frz_ok);
      logic prev;
      int   kind;
      first_e = -1; last_e = -1; edges = 0; ns = 0; nsh = 0;
      done_c = -1; ndone = 0; bc_done = -1; alt_ok = 1; frz_ok = 1; kind = 0;
      tick();
      start_i = 1'b0;
      prev = sclk_o;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (sclk_o !== prev) begin
            edges++;
            if (first_e < 0) first_e = c;
            last_e = c;
         end
         if (c > wait_at && c <= wait_at + wait_len &&
             (sclk_o !== prev || sample_o || shift_o)) frz_ok = 0;
         prev = sclk_o;
         if (sample_o && shift_o) alt_ok = 0;
         if (sample_o) begin
            if (kind == 1) alt_ok = 0;
            kind = 1; ns++;
         end
         if (shift_o) begin
            if (kind == 2) alt_ok = 0;
            kind = 2; nsh++;
         end
         if (done_o) begin
            ndone++;
            if (done_c < 0) begin done_c = c; bc_done = int'(bit_cnt_o); end
         end
         if (c == wait_at) wait_i = 1'b1;
         if (c == wait_at + wait_len) wait_i = 1'b0;
         if (done_c >= 0 && c >= done_c + 4) break;
      end
   endtask

   task automatic test_reset();
      PRESET_n = 1'b0;
      cfg(1'b1, 1'b0, 3'd0, 3'd0, 5'd1);
      #3;
      n_cmp++; if (sclk_o !== 1'b1) begin n_bad++; $display("FAIL reset_sclk: got %b want 1", sclk_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_cmp++; if ({sample_o, shift_o, done_o} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {sample_o, shift_o, done_o}); end
      n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt_o); end
      cpol_i = 1'b0; #1;
      n_cmp++; if (sclk_o !== 1'b0) begin n_bad++; $display("FAIL idle_track_cpol: got %b want 0", sclk_o); end
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET_n = 1'b1;
      tick();
   endtask

   task automatic test_divisor();
      cfg(1'b0, 1'b0, 3'd2, 3'd1, 5'd1); #1;
      n_cmp++; if (divisor_o !== 12'd12) begin n_bad++; $display("FAIL div_2_1: got %0d want 12", divisor_o); end
      cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd1); #1;
      n_cmp++; if (divisor_o !== 12'd2) begin n_bad++; $display("FAIL div_0_0: got %0d want 2", divisor_o); end
      cfg(1'b0, 1'b0, 3'd7, 3'd7, 5'd1); #1;
      n_cmp++; if (divisor_o !== 12'd2048) begin n_bad++; $display("FAIL div_7_7: got %0d want 2048", divisor_o); end
   endtask

   task automatic test_basic();
      int fe, le, ed, ns, nsh, dc, nd, bc; bit al, fz;
      cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd1);
      start_i = 1'b1;
      measure(50, -1, 0, fe, le, ed, ns, nsh, dc, nd, bc, al, fz);
      n_cmp++; if (fe !== 1) begin n_bad++; $display("FAIL basic_first_edge: got %0d want 1", fe); end
      n_cmp++; if (le !== 2) begin n_bad++; $display("FAIL basic_last_edge: got %0d want 2", le); end
      n_cmp++; if (ns !== 1 || nsh !== 0) begin n_bad++; $display("FAIL basic_strobes: got %0d/%0d want 1/0", ns, nsh); end
      n_cmp++; if (dc !== 3) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 3", dc); end
      n_cmp++; if (bc !== 1) begin n_bad++; $display("FAIL basic_bitcnt: got %0d want 1", bc); end
   endtask

   task automatic test_mode3();
      int fe, le, ed, ns, nsh, dc, nd, bc; bit al, fz;
      cfg(1'b1, 1'b1, 3'd2, 3'd1, 5'd8);
      start_i = 1'b1;
      measure(300, -1, 0, fe, le, ed, ns, nsh, dc, nd, bc, al, fz);
      n_cmp++; if (fe !== 6 || le !== 96) begin n_bad++; $display("FAIL mode3_edges_at: got %0d..%0d want 6..96", fe, le); end
      n_cmp++; if (ed !== 16) begin n_bad++; $display("FAIL mode3_edge_count: got %0d want 16", ed); end
      n_cmp++; if (ns !== 8 || nsh !== 8) begin n_bad++; $display("FAIL mode3_strobes: got %0d/%0d want 8/8", ns, nsh); end
      n_cmp++; if (al !== 1'b1) begin n_bad++; $display("FAIL mode3_alternate: got %b want 1", al); end
      n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL mode3_bitcnt: got %0d want 8", bc); end
      n_cmp++; if (dc !== 102) begin n_bad++; $display("FAIL mode3_done_cycle: got %0d want 102", dc); end
   endtask

   task automatic test_wrap();
      int fe, le, ed, ns, nsh, dc, nd, bc; bit al, fz;
      cfg(1'b0, 1'b1, 3'd0, 3'd0, 5'd0);
      start_i = 1'b1;
      measure(200, -1, 0, fe, le, ed, ns, nsh, dc, nd, bc, al, fz);
      n_cmp++; if (ed !== 64) begin n_bad++; $display("FAIL wrap_edges: got %0d want 64", ed); end
      n_cmp++; if (ns !== 32 || nsh !== 32) begin n_bad++; $display("FAIL wrap_strobes: got %0d/%0d want 32/32", ns, nsh); end
      n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL wrap_bitcnt: got %0d want 0", bc); end
      n_cmp++; if (nd !== 1 || dc !== 65) begin n_bad++; $display("FAIL wrap_done: got %0d@%0d want 1@65", nd, dc); end
      n_cmp++; if (al !== 1'b1) begin n_bad++; $display("FAIL wrap_alternate: got %b want 1", al); end
   endtask

   task automatic test_wait();
      int fe, le, ed, ns, nsh, dc, nd, bc; bit al, fz;
      cfg(1'b0, 1'b0, 3'd3, 3'd0, 5'd2);
      start_i = 1'b1;
      measure(200, 5, 10, fe, le, ed, ns, nsh, dc, nd, bc, al, fz);
      n_cmp++; if (fz !== 1'b1) begin n_bad++; $display("FAIL wait_frozen: got %b want 1", fz); end
      n_cmp++; if (ed !== 4 || le !== 26) begin n_bad++; $display("FAIL wait_edges: got %0d@%0d want 4@26", ed, le); end
      n_cmp++; if (dc !== 30) begin n_bad++; $display("FAIL wait_done_cycle: got %0d want 30", dc); end
      n_cmp++; if (ns !== 2 || nsh !== 1) begin n_bad++; $display("FAIL wait_strobes: got %0d/%0d want 2/1", ns, nsh); end
   endtask

   task automatic test_abort();
      int nd;
      cfg(1'b1, 1'b0, 3'd1, 3'd0, 5'd2);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 7; c++) tick();
      n_cmp++; if (sclk_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL abort_pre: got sclk %b busy %b want 0 1", sclk_o, busy_o); end
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_o); end
      n_cmp++; if (sclk_o !== 1'b1) begin n_bad++; $display("FAIL abort_sclk: got %b want 1", sclk_o); end
      n_cmp++; if ({sample_o, shift_o, done_o} !== 3'b000) begin n_bad++; $display("FAIL abort_strobes: got %b want 000", {sample_o, shift_o, done_o}); end
      n_cmp++; if (bit_cnt_o !== 5'd2) begin n_bad++; $display("FAIL abort_bitcnt: got %0d want 2", bit_cnt_o); end
      nd = 0;
      for (int c = 0; c < 6; c++) begin tick(); if (done_o) nd++; end
      n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", nd); end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL abort_restart: got %b want 1", busy_o); end
      nd = 0;
      for (int c = 0; c < 20 && nd == 0; c++) begin tick(); if (done_o) nd++; end
      n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL abort_restart_done: got %0d want 1", nd); end
      tick();
   endtask

   task automatic test_back_to_back();
      cfg(1'b0, 1'b0, 3'd0, 3'd0, 5'd1);
      start_i = 1'b1;
      tick();
      tick(); tick();
      n_cmp++; if (busy_o !== 1'b1 || sclk_o !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b %b want 1 0", busy_o, sclk_o); end
      tick();
      n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got %b %b want 1 0", done_o, busy_o); end
      tick();
      n_cmp++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin n_bad++; $display("FAIL b2b_restart: got %b %b want 1 0", busy_o, done_o); end
      start_i = 1'b0;
      tick();
      n_cmp++; if (sclk_o !== 1'b1 || sample_o !== 1'b1) begin n_bad++; $display("FAIL b2b_edge1: got %b %b want 1 1", sclk_o, sample_o); end
      tick(); tick();
      n_cmp++; if (done_o !== 1'b1) begin n_bad++; $display("FAIL b2b_done2: got %b want 1", done_o); end
      tick();
   endtask

   task automatic test_reset_midframe();
      cfg(1'b1, 1'b0, 3'd1, 3'd0, 5'd4);
      start_i = 1'b1;
      tick();
      tick();
      cpol_i = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if (sclk_o !== 1'b1 || busy_o !== 1'b1 || bit_cnt_o !== 5'd1) begin n_bad++; $display("FAIL midframe_ignore: got sclk %b busy %b cnt %0d want 1 1 1", sclk_o, busy_o, bit_cnt_o); end
      tick(); tick();
      n_cmp++; if (sclk_o !== 1'b0) begin n_bad++; $display("FAIL midframe_edge3: got %b want 0", sclk_o); end
      start_i = 1'b0;
      cpol_i = 1'b1;
      #2;
      PRESET_n = 1'b0;
      #1;
      n_cmp++; if (sclk_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL midframe_reset: got sclk %b busy %b want 1 0", sclk_o, busy_o); end
      n_cmp++; if (bit_cnt_o !== 5'd0) begin n_bad++; $display("FAIL midframe_reset_cnt: got %0d want 0", bit_cnt_o); end
      @(negedge PCLK);
      PRESET_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      start_i = 1'b0; abort_i = 1'b0; wait_i = 1'b0;
      cpol_i = 1'b0; cpha_i = 1'b0;
      sppr_i = '0; spr_i = '0; frame_len_i = '0;
      test_reset();
      test_divisor();
      test_basic();
      test_mode3();
      test_wrap();
      test_wait();
      test_abort();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
